mem_port_arbiter: RTL and testbench

Two-port sequencing controller for the 16-byte strobe-driven memory (4-bit address, 8-bit data, separate Read/Write strobes that act on their rising edge). It accepts read/write requests from two requesters, arbitrates round-robin, and drives the memory's address, data and strobe pins with a fixed, glitch-free setup/strobe/capture sequence. It sits between the CPU-side masters and the memory, and is the only block allowed to drive the memory pins.

---
 rtl/mem_ctrl_pkg.sv | 19 +
 rtl/rr_arb2.sv | 27 ++
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the two-port strobe-memory sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, default memory geometry, transaction length.
package mem_ctrl_pkg;

    localparam int DEF_ADDR_W     = 4;   // 16 memory locations
    localparam int DEF_DATA_W     = 8;   // byte-wide memory
    localparam int CYCLES_PER_TXN = 4;   // IDLE + SETUP + STROBE + DONE

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; the 'last' history register lives in the parent.
// Latency: purely combinational.
// Backpressure: none; 'en' low suppresses any grant.
//
// Ports:
//   req[1:0]  request levels          last  port served most recently
//   en        arbitration allowed     gnt_valid / gnt_id  winning port
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       en,
    output logic       gnt_valid,
    output logic       gnt_id
);

    always_comb begin
        gnt_valid = en & (req[0] | req[1]);
        gnt_id    = 1'b0;
        if (req[0] && req[1]) begin
            // contested: the port that was not served last time wins
            gnt_id = ~last;
        end else if (req[1]) begin
            gnt_id = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin sequencer driving a strobe-edge 16x8 memory.
// Latency: grant edge k -> SETUP k+1, STROBE k+2, DONE/rdata k+3, IDLE k+4.
// Backpressure: requesters hold req until done; one transaction in flight.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   req/we/addr/wdata{0,1}          per-port request, sampled on the grant edge
//   done{0,1}, rdata{0,1}           completion pulse and held read result
//   busy, gnt_id                    FSM not idle, port currently/last served
//   mem_addr/mem_wdata/mem_read/mem_write/mem_rdata   memory pins
module mem_port_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic              gnt_id,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e              state_q, state_d;
    logic                last_q, last_d;
    logic                gnt_q, gnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic                done0_q, done0_d;
    logic                done1_q, done1_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;

    logic                arb_vld;
    logic                arb_id;

    rr_arb2 u_arb (
        .req       ({req1, req0}),
        .last      (last_q),
        .en        (state_q == ST_IDLE),
        .gnt_valid (arb_vld),
        .gnt_id    (arb_id)
    );

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        we_d        = we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        // strobes and done are single-cycle pulses: low unless set below
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        done0_d     = 1'b0;
        done1_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arb_vld) begin
                    state_d = ST_SETUP;
                    last_d  = arb_id;
                    gnt_d   = arb_id;
                    // the memory address/data registers double as the
                    // transaction latch, so the pins only move on this edge
                    we_d        = arb_id ? we1    : we0;
                    mem_addr_d  = arb_id ? addr1  : addr0;
                    mem_wdata_d = arb_id ? wdata1 : wdata0;
                end
            end
            ST_SETUP: begin
                state_d     = ST_STROBE;
                mem_write_d = we_q;
                mem_read_d  = ~we_q;
            end
            ST_STROBE: begin
                state_d = ST_DONE;
                done0_d = ~gnt_q;
                done1_d = gnt_q;
                // memory output settled after the read strobe's rising edge
                if (!we_q) begin
                    if (gnt_q) rdata1_d = mem_rdata;
                    else       rdata0_d = mem_rdata;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            last_q      <= 1'b1;
            gnt_q       <= 1'b0;
            we_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            we_q        <= we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

    assign done0     = done0_q;
    assign done1     = done1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign busy      = (state_q != ST_IDLE);
    assign gnt_id    = gnt_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a behavioural strobe memory.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_port_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rq [2];
    logic       w  [2];
    logic [3:0] a  [2];
    logic [7:0] d  [2];
    logic       done0, done1, busy, gnt_id, mem_read, mem_write;
    logic [7:0] rdata0, rdata1, mem_wdata;
    logic [3:0] mem_addr;
    logic [7:0] mem_rdata = 8'h00;
    logic [1:0] dn;
    logic [7:0] rd [2];

    logic [7:0] mem_arr [16];
    logic [7:0] ref_mem [16];

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       port;
        logic       we;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rd0;
        logic [7:0] exp_rd1;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    assign dn    = {done1, done0};
    assign rd[0] = rdata0;
    assign rd[1] = rdata1;

    // behavioural memory: acts on the rising edge of each strobe
    always @(posedge mem_write) mem_arr[mem_addr] = mem_wdata;
    always @(posedge mem_read)  mem_rdata = mem_arr[mem_addr];

    mem_port_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (rq[0]),
        .req1      (rq[1]),
        .we0       (w[0]),
        .we1       (w[1]),
        .addr0     (a[0]),
        .addr1     (a[1]),
        .wdata0    (d[0]),
        .wdata1    (d[1]),
        .done0     (done0),
        .done1     (done1),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .busy      (busy),
        .gnt_id    (gnt_id),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_rdata (mem_rdata)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int p = 0; p < 2; p++) begin
            rq[p] = 1'b0; w[p] = 1'b0; a[p] = 4'h0; d[p] = 8'h00;
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // one transaction on an idle DUT, checked cycle by cycle
    task automatic do_txn(input vec_t v, input string nm);
        logic p;
        p = v.port;
        rq[p] = 1'b1; w[p] = v.we; a[p] = v.addr; d[p] = v.wdata;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check({nm, "_gnt"}, gnt_id, p);
                check({nm, "_addr"}, mem_addr, v.addr);
                if (v.we) check({nm, "_wdata"}, mem_wdata, v.wdata);
            end
            check({nm, "_wr"}, mem_write, (c == 2) && v.we);
            check({nm, "_rd"}, mem_read, (c == 2) && !v.we);
            check({nm, "_done"}, dn[p], c == 3);
            check({nm, "_done_other"}, dn[~p], 1'b0);
            check({nm, "_busy"}, busy, c <= 3);
            if (c == 3) begin
                check({nm, "_rdata0"}, rdata0, v.exp_rd0);
                check({nm, "_rdata1"}, rdata1, v.exp_rd1);
                rq[p] = 1'b0;
            end
        end
    endtask

    // both ports already requesting; each drops req on its own done
    task automatic run_both(output int first_p, output int second_p, output int gap);
        int n;
        int c1;
        n = 0; c1 = 0; first_p = -1; second_p = -1; gap = -1;
        for (int c = 0; c < 24 && n < 2; c++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (dn[p] === 1'b1) begin
                    rq[p] = 1'b0;
                    if (n == 0) begin first_p = p; c1 = c; end
                    else begin second_p = p; gap = c - c1; end
                    n++;
                end
            end
        end
        check("both_done_count", n, 2);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int fp, sp, gp, ndone, last_c, pe, e, next_free, g_edge, m_done_edge;
        logic prev_done, prev_strobe, cur_strobe, last_port, port, win;
        logic m_last, m_gnt, m_we, m_port;
        logic [7:0] m_res, m_mwdata, v8;
        logic [3:0] m_maddr;
        logic [7:0] m_rd [2];
        logic infl [2];

        for (int i = 0; i < 16; i++) mem_arr[i] = 8'h00;
        do_reset();

        // reset state
        check("rst_busy", busy, 1'b0);
        check("rst_done0", done0, 1'b0);
        check("rst_done1", done1, 1'b0);
        check("rst_rdata0", rdata0, 8'h00);
        check("rst_rdata1", rdata1, 8'h00);
        check("rst_gnt", gnt_id, 1'b0);
        check("rst_maddr", mem_addr, 4'h0);
        check("rst_mwdata", mem_wdata, 8'h00);
        check("rst_mrd", mem_read, 1'b0);
        check("rst_mwr", mem_write, 1'b0);

        // single transactions: {port, we, addr, wdata, rdata0 after, rdata1 after}
        vecs[0] = '{1'b0, 1'b1, 4'd3,  8'hA5, 8'h00, 8'h00};
        vecs[1] = '{1'b1, 1'b0, 4'd3,  8'h00, 8'h00, 8'hA5};
        vecs[2] = '{1'b0, 1'b0, 4'd3,  8'h00, 8'hA5, 8'hA5};
        vecs[3] = '{1'b1, 1'b1, 4'd15, 8'hFF, 8'hA5, 8'hA5};
        vecs[4] = '{1'b0, 1'b0, 4'd15, 8'h00, 8'hFF, 8'hA5};
        vecs[5] = '{1'b1, 1'b0, 4'd9,  8'h00, 8'hFF, 8'h00};
        vecs[6] = '{1'b0, 1'b1, 4'd9,  8'h3C, 8'hFF, 8'h00};
        vecs[7] = '{1'b1, 1'b0, 4'd9,  8'h00, 8'hFF, 8'h3C};
        for (int i = 0; i < 8; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

        // simultaneous requests straight after reset: port 0 first
        do_reset();
        rq[0] = 1'b1; w[0] = 1'b1; a[0] = 4'd0; d[0] = 8'h11;
        rq[1] = 1'b1; w[1] = 1'b1; a[1] = 4'd0; d[1] = 8'h22;
        run_both(fp, sp, gp);
        check("simw_first", fp, 0);
        check("simw_second", sp, 1);
        check("simw_gap", gp, 4);
        @(negedge clk);
        check("simw_mem0", mem_arr[0], 8'h22);
        rq[0] = 1'b1; w[0] = 1'b0; a[0] = 4'd0;
        rq[1] = 1'b1; w[1] = 1'b0; a[1] = 4'd0;
        run_both(fp, sp, gp);
        check("simr_first", fp, 0);
        check("simr_second", sp, 1);
        check("simr_rdata0", rdata0, 8'h22);
        check("simr_rdata1", rdata1, 8'h22);
        @(negedge clk);

        // continuous requests from both ports for 8 transactions
        rq[0] = 1'b1; w[0] = 1'b0; a[0] = 4'd3;
        rq[1] = 1'b1; w[1] = 1'b0; a[1] = 4'd15;
        ndone = 0; last_c = 0; prev_done = 1'b0; prev_strobe = 1'b0; last_port = 1'b0;
        for (int c = 0; c < 48 && ndone < 8; c++) begin
            @(negedge clk);
            check("cont_busy", busy, !prev_done);
            cur_strobe = mem_read | mem_write;
            check("cont_strobe_twice", prev_strobe & cur_strobe, 1'b0);
            if ((done0 | done1) === 1'b1) begin
                port = done1;
                check("cont_both_done", done0 & done1, 1'b0);
                if (ndone == 0) check("cont_first", port, 1'b0);
                else begin
                    check("cont_gap", c - last_c, 4);
                    check("cont_alt", port, !last_port);
                end
                last_c = c; last_port = port; ndone++;
            end
            prev_done = done0 | done1;
            prev_strobe = cur_strobe;
        end
        check("cont_count", ndone, 8);
        check("cont_rdata0", rdata0, 8'hA5);
        check("cont_rdata1", rdata1, 8'hFF);
        rq[0] = 1'b0; rq[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // port inputs change during SETUP/STROBE
        rq[0] = 1'b1; w[0] = 1'b1; a[0] = 4'd5; d[0] = 8'h77;
        @(negedge clk);
        check("hold_setup_addr", mem_addr, 4'd5);
        check("hold_setup_data", mem_wdata, 8'h77);
        w[0] = 1'b0; a[0] = 4'd6; d[0] = 8'h99;
        @(negedge clk);
        check("hold_strobe_wr", mem_write, 1'b1);
        check("hold_strobe_rd", mem_read, 1'b0);
        check("hold_strobe_addr", mem_addr, 4'd5);
        check("hold_strobe_data", mem_wdata, 8'h77);
        a[0] = 4'hC; d[0] = 8'h12;
        @(negedge clk);
        check("hold_done", done0, 1'b1);
        check("hold_done_addr", mem_addr, 4'd5);
        rq[0] = 1'b0;
        @(negedge clk);
        check("hold_mem5", mem_arr[5], 8'h77);
        check("hold_mem6", mem_arr[6], 8'h00);

        // reset during SETUP of a write: nothing reaches memory
        rq[0] = 1'b1; w[0] = 1'b1; a[0] = 4'd7; d[0] = 8'h5A;
        @(negedge clk);
        reset = 1'b1; rq[0] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            reset = 1'b0;
            check("rs_setup_wr", mem_write, 1'b0);
            check("rs_setup_rd", mem_read, 1'b0);
            check("rs_setup_done", done0, 1'b0);
            check("rs_setup_busy", busy, 1'b0);
        end
        check("rs_setup_mem7", mem_arr[7], 8'h00);

        // reset during STROBE of a write: write lands, no done
        rq[1] = 1'b1; w[1] = 1'b1; a[1] = 4'd8; d[1] = 8'h3C;
        @(negedge clk);
        @(negedge clk);
        check("rs_strobe_wr_hi", mem_write, 1'b1);
        reset = 1'b1; rq[1] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            reset = 1'b0;
            check("rs_strobe_wr", mem_write, 1'b0);
            check("rs_strobe_done", done1, 1'b0);
            check("rs_strobe_busy", busy, 1'b0);
        end
        check("rs_strobe_mem8", mem_arr[8], 8'h3C);
        check("rs_strobe_rdata1", rdata1, 8'h00);

        // req1 held through DONE: served again, rdata0 untouched
        vecs[0] = '{1'b0, 1'b0, 4'd3, 8'h00, 8'hA5, 8'h00};
        do_txn(vecs[0], "pre_held");
        rq[1] = 1'b1; w[1] = 1'b0; a[1] = 4'd15;
        ndone = 0; last_c = 0; gp = -1;
        for (int c = 0; c < 20 && ndone < 2; c++) begin
            @(negedge clk);
            check("held_rdata0", rdata0, 8'hA5);
            check("held_done0", done0, 1'b0);
            if (done1 === 1'b1) begin
                if (ndone == 1) gp = c - last_c;
                last_c = c; ndone++;
            end
        end
        check("held_count", ndone, 2);
        check("held_gap", gp, 4);
        check("held_rdata1", rdata1, 8'hFF);
        rq[1] = 1'b0;
        @(negedge clk);

        // randomized traffic against a transaction-level model
        do_reset();
        for (int i = 0; i < 16; i++) begin
            v8 = 8'($urandom_range(0, 255));
            mem_arr[i] = v8;
            ref_mem[i] = v8;
        end
        e = 0; next_free = 0; g_edge = -100; m_done_edge = -100;
        m_last = 1'b1; m_gnt = 1'b0; m_we = 1'b0; m_port = 1'b0; m_res = 8'h00;
        m_maddr = 4'h0; m_mwdata = 8'h00; m_rd[0] = 8'h00; m_rd[1] = 8'h00;
        infl[0] = 1'b0; infl[1] = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            pe = e - 1;
            if (cyc > 0) begin
                if (pe == m_done_edge && !m_we) m_rd[m_port] = m_res;
                check("rnd_done0", done0, pe == m_done_edge && m_port == 1'b0);
                check("rnd_done1", done1, pe == m_done_edge && m_port == 1'b1);
                check("rnd_rdata0", rdata0, m_rd[0]);
                check("rnd_rdata1", rdata1, m_rd[1]);
                check("rnd_busy", busy, pe >= g_edge && pe <= g_edge + 2);
                check("rnd_gnt", gnt_id, m_gnt);
                check("rnd_maddr", mem_addr, m_maddr);
                check("rnd_mwdata", mem_wdata, m_mwdata);
                check("rnd_mwr", mem_write, pe == g_edge + 1 && m_we);
                check("rnd_mrd", mem_read, pe == g_edge + 1 && !m_we);
            end
            for (int p = 0; p < 2; p++) begin
                if (infl[p] && pe == m_done_edge && m_port == 1'(p)) begin
                    infl[p] = 1'b0;
                    // sometimes keep requesting: a fresh transaction
                    if ($urandom_range(0, 3) == 0) begin
                        w[p] = 1'($urandom_range(0, 1));
                        a[p] = 4'($urandom_range(0, 15));
                        d[p] = 8'($urandom_range(0, 255));
                    end else begin
                        rq[p] = 1'b0;
                    end
                end else if (infl[p]) begin
                    w[p] = 1'($urandom_range(0, 1));
                    a[p] = 4'($urandom_range(0, 15));
                    d[p] = 8'($urandom_range(0, 255));
                end else if (!rq[p] && $urandom_range(0, 2) == 0) begin
                    rq[p] = 1'b1;
                    w[p] = 1'($urandom_range(0, 1));
                    a[p] = 4'($urandom_range(0, 15));
                    d[p] = 8'($urandom_range(0, 255));
                end
            end
            if (e >= next_free && (rq[0] || rq[1])) begin
                if (rq[0] && rq[1]) win = !m_last;
                else if (rq[0])     win = 1'b0;
                else                win = 1'b1;
                m_last = win; m_gnt = win; m_port = win;
                g_edge = e; m_done_edge = e + 2; next_free = e + 4;
                m_we = w[win]; m_maddr = a[win]; m_mwdata = d[win];
                if (m_we) ref_mem[m_maddr] = m_mwdata;
                else      m_res = ref_mem[m_maddr];
                infl[win] = 1'b1;
            end
            @(negedge clk);
            e++;
        end
        rq[0] = 1'b0; rq[1] = 1'b0;
        for (int c = 0; c < 6; c++) @(negedge clk);
        for (int i = 0; i < 16; i++) check($sformatf("rnd_mem%0d", i), mem_arr[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
